// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
// Contents: op_t request codes, state_t FSM states, the iteration counter
// width, the divide-by-zero LO value, and a signed-op helper.
package muldiv_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ITER_W         = $clog2(DATA_WIDTH_DEF) + 1;
  localparam logic [DATA_WIDTH_DEF-1:0] DIVZERO_LO = '1;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // Operands of MULT/DIV are two's complement; everything else is raw.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational conditional negation of a pair of lanes.
// Input side: turns signed operands into magnitudes (i_link=0).
// Output side: applies result sign; with i_link=1 the lanes form one
// 2*WIDTH value {i_hi,i_lo} negated as a whole (product), otherwise each
// lane is negated on its own (quotient / remainder).
// Ports: i_hi, i_lo values; i_neg_hi, i_neg_lo negate enables;
//        i_link joins lanes; o_hi, o_lo results.
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic             i_neg_hi,
  input  logic             i_neg_lo,
  input  logic             i_link,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] w_lo_neg;
  logic [WIDTH-1:0] w_hi_neg;
  logic [WIDTH-1:0] w_hi_linked;

  assign w_lo_neg    = ~i_lo + WIDTH'(1);
  assign w_hi_neg    = ~i_hi + WIDTH'(1);
  // Upper half of a double-width negation: the +1 carries in only when
  // the low half is zero.
  assign w_hi_linked = ~i_hi + WIDTH'(i_lo == '0);

  always_comb begin
    o_lo = i_neg_lo ? w_lo_neg : i_lo;
    if (i_link) begin
      o_hi = i_neg_lo ? w_hi_linked : i_hi;
    end else begin
      o_hi = i_neg_hi ? w_hi_neg : i_hi;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, followed by a
// single sign-correction cycle. MTHI/MTLO write HI/LO directly from IDLE.
// Ports: clk, rst_n (async active-low); start/op/a/b request (sampled in
//        IDLE only); abort synchronous flush; busy, done (1-cycle pulse),
//        hi, lo registered outputs.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned DW = DATA_WIDTH;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ITER_W-1:0] r_cnt;
  logic [2*DW-1:0]   r_acc;
  logic [DW-1:0]     r_mcand;
  logic [DW-1:0]     r_div;
  logic [DW-1:0]     r_quo;
  logic [DW-1:0]     r_rem;
  logic [DW-1:0]     r_a_raw;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_divzero;
  logic              r_is_mul;
  logic [DW-1:0]     r_hi;
  logic [DW-1:0]     r_lo;
  logic              r_busy;
  logic              r_done;

  logic              w_is_signed;
  logic [DW-1:0]     w_mag_a;
  logic [DW-1:0]     w_mag_b;
  logic              w_last;
  logic [DW:0]       w_mul_sum;
  logic [DW:0]       w_div_shift;
  logic              w_div_ge;
  logic [DW-1:0]     w_div_diff;
  logic [DW-1:0]     w_fix_hi;
  logic [DW-1:0]     w_fix_lo;
  logic [DW-1:0]     w_res_hi;
  logic [DW-1:0]     w_res_lo;
  logic              w_ld_mul;
  logic              w_ld_div;
  logic              w_mthi;
  logic              w_mtlo;
  logic              w_wr_fix;

  assign w_is_signed = is_signed_op(op);
  assign w_last      = (r_cnt == ITER_W'(DW - 1));

  // Operand magnitudes (a on the hi lane, b on the lo lane).
  muldiv_signfix #(.WIDTH(DW)) u_sign_in (
    .i_hi     (a),
    .i_lo     (b),
    .i_neg_hi (w_is_signed & a[DW-1]),
    .i_neg_lo (w_is_signed & b[DW-1]),
    .i_link   (1'b0),
    .o_hi     (w_mag_a),
    .o_lo     (w_mag_b)
  );

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  assign w_mul_sum = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

  // Restoring divide step: bring in the next dividend bit and subtract when
  // the partial remainder covers the divisor. The difference always fits DW.
  assign w_div_shift = {r_rem, r_quo[DW-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_div});
  assign w_div_diff  = w_div_shift[DW-1:0] - r_div;

  // Result sign correction: product negated as one value, quotient and
  // remainder independently.
  muldiv_signfix #(.WIDTH(DW)) u_sign_out (
    .i_hi     (r_is_mul ? r_acc[2*DW-1:DW] : r_rem),
    .i_lo     (r_is_mul ? r_acc[DW-1:0]    : r_quo),
    .i_neg_hi (r_neg_r),
    .i_neg_lo (r_neg_q),
    .i_link   (r_is_mul),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  // Divide by zero bypasses the datapath result entirely.
  assign w_res_hi = (!r_is_mul && r_divzero) ? r_a_raw          : w_fix_hi;
  assign w_res_lo = (!r_is_mul && r_divzero) ? DW'(DIVZERO_LO) : w_fix_lo;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_mul    = 1'b0;
    w_ld_div    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    w_wr_fix    = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                w_ld_mul    = 1'b1;
                w_state_nxt = S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                w_ld_div    = 1'b1;
                w_state_nxt = S_DIV;
              end
              OP_MTHI: w_mthi = 1'b1;
              OP_MTLO: w_mtlo = 1'b1;
              default: ;
            endcase
          end
        end
        S_MUL: if (w_last) w_state_nxt = S_FIX;
        S_DIV: if (w_last) w_state_nxt = S_FIX;
        S_FIX: begin
          w_wr_fix    = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Iteration datapath and operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_div     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_a_raw   <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_divzero <= 1'b0;
      r_is_mul  <= 1'b0;
    end else if (w_ld_mul) begin
      r_mcand   <= w_mag_a;
      r_acc     <= {{DW{1'b0}}, w_mag_b};
      r_cnt     <= '0;
      r_is_mul  <= 1'b1;
      r_neg_q   <= w_is_signed & (a[DW-1] ^ b[DW-1]);
      r_neg_r   <= 1'b0;
      r_divzero <= 1'b0;
    end else if (w_ld_div) begin
      r_div     <= w_mag_b;
      r_quo     <= w_mag_a;
      r_rem     <= '0;
      r_a_raw   <= a;
      r_cnt     <= '0;
      r_is_mul  <= 1'b0;
      r_neg_q   <= w_is_signed & (a[DW-1] ^ b[DW-1]);
      r_neg_r   <= w_is_signed & a[DW-1];
      r_divzero <= (b == '0);
    end else if (r_state == S_MUL) begin
      r_acc <= {w_mul_sum, r_acc[DW-1:1]};
      r_cnt <= r_cnt + ITER_W'(1);
    end else if (r_state == S_DIV) begin
      r_rem <= w_div_ge ? w_div_diff : w_div_shift[DW-1:0];
      r_quo <= {r_quo[DW-2:0], w_div_ge};
      r_cnt <= r_cnt + ITER_W'(1);
    end
  end

  // Architectural HI/LO and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_mthi)   r_hi <= a;
      if (w_mtlo)   r_lo <= a;
      if (w_wr_fix) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_wr_fix;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers for the MIPS core.
- Sequences MULT, MULTU, DIV, DIVU, MTHI and MTLO, replacing single-cycle combinational mul/div in the ALU.
- Sits beside the ALU in the execute stage. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width. Iteration count = DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  3  muldiv_pkg::op_t: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6-7 reserved
- a  input  DATA_WIDTH  rs operand (multiplicand/dividend/MTxx source)
- b  input  DATA_WIDTH  rt operand (multiplier/divisor)
- abort  input  1  synchronous flush (exception/branch squash)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: new HI/LO visible
- hi  output  DATA_WIDTH  HI register
- lo  output  DATA_WIDTH  LO register

Behaviour:
- Reset (rst_n=0, async) forces: state=IDLE, hi=0, lo=0, busy=0, done=0, and clears the counter and internal registers. This applies immediately, including mid-operation.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, op MULT/MULTU:
  - Latch |a| and |b| (signed ops) or raw values (unsigned ops).
  - Record result sign = a[31]^b[31] (signed only).
  - Clear the 64-bit accumulator, set cnt=0, go to MUL.
- IDLE, start=1, op DIV/DIVU:
  - Latch magnitudes as above.
  - Record quotient sign = a[31]^b[31] and remainder sign = a[31] (signed only).
  - Go to DIV.
- IDLE, start=1, op MTHI/MTLO: hi (resp. lo) <= a at that edge. No busy, no done. Remains IDLE.
- IDLE, start=1, reserved op: ignored.
- MUL: shift-add, one multiplier bit per cycle, 32 cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, 32 cycles, then FIX.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - Write hi/lo. MUL: hi=product[63:32], lo=product[31:0]. DIV: lo=quotient, hi=remainder.
  - Go to IDLE.
  - done=1 in the cycle after the FIX edge; busy=0 in that same cycle.
- Latency: start sampled at edge N; hi/lo updated at edge N+33; done high during cycle N+33..N+34.
- busy=1 exactly while state is MUL, DIV or FIX.
- Signed division truncates toward zero; remainder takes the dividend's sign.
- Divide by zero, any signedness: lo=32'hFFFFFFFF, hi=a (original value). Same latency, no sign correction.
- 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. Falls out of magnitude arithmetic; must not hang.
- start while busy: ignored entirely. Operands are not relatched and MTHI/MTLO are dropped. The pipeline guarantees stall.
- abort=1:
  - In any state, go to IDLE at the next edge. hi/lo unchanged, no done pulse, busy=0 next cycle.
  - abort and start in the same IDLE cycle: abort wins, request dropped (MTHI/MTLO included).
- hi/lo change only at FIX, on MTHI/MTLO, or on reset. They hold old values throughout MUL/DIV.
- No X propagation. Reserved op/state encodings default to IDLE.

Decomposition:
- muldiv_pkg: op_t enum (codes above), state_t enum, ITER_W=$clog2(DATA_WIDTH)+1, DIVZERO_LO constant.
- One sub-module, muldiv_signfix (combinational): magnitude-in and sign-out for operands, plus result negation for FIX. It is instantiated once for the input side and once for the output side.
- The FSM, counter and shift datapath stay in muldiv_sequencer.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. busy high 33 cycles; done one cycle at start+33.
2. MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234. Same for DIV a=0xFFFFFFF0 b=0 -> hi=0xFFFFFFF0.
5. MTHI a=0xAAAA5555 when idle -> hi updates next edge, no done. Then MULTU 2*3; start=1 op=MTLO at cycle 10 -> ignored. Final lo=6, hi=0.
6. MULTU 5*5 with abort at cycle 12 -> idle next cycle, hi/lo keep prior values, no done. Then start DIVU and drop rst_n at cycle 20 -> hi=lo=0, busy=0 immediately without a clock edge.
